lane_queue_tracker: RTL and testbench

- Produces the packed per-lane car-count bus that feeds the intersection controller's `lanes` input; it is the counting source for that bus.
- Counts car arrivals per lane from sensor pulses and removes cars while that lane's car light is green.
- Departures start after a startup delay and then occur at a fixed discharge rate.
- Reports per-lane occupancy, a sticky overflow, and an intersection-wide total.

---
 rtl/lane_queue_tracker_if.sv | 27 ++
 rtl/lane_queue_tracker.sv | 134 +++++++++++++
 tb/tb_lane_queue_tracker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lane_queue_tracker_if.sv
// Lane queue tracker bus: sensor/light inputs and per-lane count outputs.
// master drives sensors and lights; slave is the tracker itself.
interface lane_queue_tracker_if #(
    parameter int NUM_LANES = 8,
    parameter int COUNT_W   = 8,
    parameter int TOTAL_W   = 11
);
    logic [NUM_LANES-1:0]         carArrive;
    logic [NUM_LANES-1:0]         greenLights;
    logic [NUM_LANES*COUNT_W-1:0] lanes;
    logic [NUM_LANES-1:0]         laneBusy;
    logic [NUM_LANES-1:0]         departPulse;
    logic [NUM_LANES-1:0]         overflow;
    logic [TOTAL_W-1:0]           totalCars;

    modport master (
        output carArrive, greenLights,
        input  lanes, laneBusy, departPulse,
        input  overflow, totalCars
    );

    modport slave (
        input  carArrive, greenLights,
        output lanes, laneBusy, departPulse,
        output overflow, totalCars
    );
endinterface

// File: rtl/lane_queue_tracker.sv
// Per-lane car counters with green-light discharge scheduling.
// Each lane runs an independent RED/STARTUP/FLOW departure FSM.
module lane_queue_tracker #(
    parameter int NUM_LANES       = 8,
    parameter int COUNT_W         = 8,
    parameter int START_DELAY     = 3,
    parameter int DEPART_INTERVAL = 2,
    parameter int TOTAL_W         = 11
) (
    input  logic                clk,
    input  logic                rst,
    lane_queue_tracker_if.slave bus
);
    localparam int MAXT =
        (START_DELAY > DEPART_INTERVAL) ? START_DELAY : DEPART_INTERVAL;
    localparam int TMR_W = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [TMR_W-1:0] START_LD = TMR_W'(START_DELAY - 1);
    localparam logic [TMR_W-1:0] DEP_LD   = TMR_W'(DEPART_INTERVAL - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {RED, STARTUP, FLOW} st_e;

    st_e                  state_q [NUM_LANES];
    st_e                  state_d [NUM_LANES];
    logic [TMR_W-1:0]     timer_q [NUM_LANES];
    logic [TMR_W-1:0]     timer_d [NUM_LANES];
    logic [COUNT_W-1:0]   count_q [NUM_LANES];
    logic [COUNT_W-1:0]   count_d [NUM_LANES];
    logic [NUM_LANES-1:0] attempt;
    logic [NUM_LANES-1:0] depart_d, depart_q;
    logic [NUM_LANES-1:0] ovf_d, ovf_q;
    logic [TOTAL_W-1:0]   total_d, total_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= RED;
                timer_q[i] <= '0;
                count_q[i] <= '0;
            end
            depart_q <= '0;
            ovf_q    <= '0;
            total_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state_q[i] <= state_d[i];
                timer_q[i] <= timer_d[i];
                count_q[i] <= count_d[i];
            end
            depart_q <= depart_d;
            ovf_q    <= ovf_d;
            total_q  <= total_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_LANES; i++) begin
            state_d[i] = state_q[i];
            timer_d[i] = timer_q[i];
            unique case (state_q[i])
                RED: begin
                    if (bus.greenLights[i]) begin
                        state_d[i] = STARTUP;
                        timer_d[i] = START_LD;
                    end
                end
                STARTUP: begin
                    if (!bus.greenLights[i]) begin
                        state_d[i] = RED;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == '0) begin
                        state_d[i] = FLOW;
                        timer_d[i] = DEP_LD;
                    end else begin
                        timer_d[i] = timer_q[i] - 1'b1;
                    end
                end
                FLOW: begin
                    if (!bus.greenLights[i]) begin
                        state_d[i] = RED;
                        timer_d[i] = '0;
                    end else if (timer_q[i] == '0) begin
                        timer_d[i] = DEP_LD;
                    end else begin
                        timer_d[i] = timer_q[i] - 1'b1;
                    end
                end
                default: begin
                    state_d[i] = RED;
                    timer_d[i] = '0;
                end
            endcase
        end
    end

    // Slots fire on schedule even when empty; only a real car pulses.
    always_comb begin
        attempt  = '0;
        depart_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            attempt[i] = bus.greenLights[i]
                       && (timer_q[i] == '0)
                       && (state_q[i] != RED);
            depart_d[i] = attempt[i] && (count_q[i] != '0);
        end
    end

    always_comb begin
        ovf_d   = ovf_q;
        total_d = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            count_d[i] = count_q[i];
            if (bus.carArrive[i] && !depart_d[i]) begin
                if (count_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    count_d[i] = count_q[i] + 1'b1;
                end
            end else if (!bus.carArrive[i] && depart_d[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
            total_d = total_d + TOTAL_W'(count_d[i]);
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_out
        assign bus.lanes[COUNT_W*g +: COUNT_W] = count_q[g];
        assign bus.laneBusy[g] = |count_q[g];
    end

    assign bus.departPulse = depart_q;
    assign bus.overflow    = ovf_q;
    assign bus.totalCars   = total_q;
endmodule

// File: tb/tb_lane_queue_tracker.sv
// Directed bench for lane_queue_tracker with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs sampled there too.
module tb_lane_queue_tracker;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cnt;

    lane_queue_tracker_if bus ();

    lane_queue_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.carArrive   = '0;
        bus.greenLights = '0;

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rst_lanes", 32'(bus.lanes != 0), 0);
        chk("rst_total", 32'(bus.totalCars), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_dep", 32'(bus.departPulse), 0);
        chk("rst_busy", 32'(bus.laneBusy), 0);

        // 2: arrivals on lanes 3 and 0
        for (int k = 0; k < 5; k++) begin
            bus.carArrive = (k < 2) ? 8'b0000_1001 : 8'b0000_1000;
            tick();
        end
        bus.carArrive = '0;
        chk("arr_l3", 32'(bus.lanes[24 +: 8]), 5);
        chk("arr_l0", 32'(bus.lanes[0 +: 8]), 2);
        chk("arr_total", 32'(bus.totalCars), 7);
        chk("arr_busy", 32'(bus.laneBusy), 32'h09);

        // 3: discharge lane 3; edge 0 samples green
        bus.greenLights = 8'h08;
        tick();
        chk("dis_e0_dep", 32'(bus.departPulse), 0);
        cnt = 5;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (e >= 3 && e <= 11 && (e % 2) == 1) begin
                cnt--;
                chk($sformatf("dis_e%0d_dep", e),
                    32'(bus.departPulse), 32'h08);
            end else begin
                chk($sformatf("dis_e%0d_dep", e),
                    32'(bus.departPulse), 0);
            end
            chk($sformatf("dis_e%0d_cnt", e),
                32'(bus.lanes[24 +: 8]), 32'(cnt));
        end
        chk("dis_total", 32'(bus.totalCars), 2);
        chk("dis_busy", 32'(bus.laneBusy), 32'h01);

        // 4: green drop after one departure
        bus.greenLights = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.carArrive = 8'h08;
            tick();
        end
        bus.carArrive = '0;
        chk("drop_pre", 32'(bus.lanes[24 +: 8]), 4);
        bus.greenLights = 8'h08;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk($sformatf("drop_e%0d_dep", e),
                32'(bus.departPulse), (e == 3) ? 32'h08 : 0);
        end
        bus.greenLights = '0;
        tick();
        chk("drop_off_dep", 32'(bus.departPulse), 0);
        tick();
        tick();
        chk("drop_cnt", 32'(bus.lanes[24 +: 8]), 3);
        bus.greenLights = 8'h08;
        for (int e = 0; e < 4; e++) begin
            tick();
            chk($sformatf("re_e%0d_dep", e),
                32'(bus.departPulse), (e == 3) ? 32'h08 : 0);
        end
        bus.greenLights = '0;
        tick();
        chk("re_cnt", 32'(bus.lanes[24 +: 8]), 2);

        // 5: saturation on lane 7
        bus.carArrive = 8'h80;
        for (int k = 0; k < 260; k++) tick();
        bus.carArrive = '0;
        chk("sat_cnt", 32'(bus.lanes[56 +: 8]), 255);
        chk("sat_ovf", 32'(bus.overflow), 32'h80);
        chk("sat_total", 32'(bus.totalCars), 259);
        bus.greenLights = 8'h80;
        tick();
        tick();
        tick();
        bus.carArrive = 8'h80;
        tick();
        bus.carArrive = '0;
        chk("sat_ad_dep", 32'(bus.departPulse), 32'h80);
        chk("sat_ad_cnt", 32'(bus.lanes[56 +: 8]), 255);
        chk("sat_ad_ovf", 32'(bus.overflow), 32'h80);
        tick();
        tick();
        chk("sat_flow_dep", 32'(bus.departPulse), 32'h80);
        chk("sat_flow_cnt", 32'(bus.lanes[56 +: 8]), 254);

        // 6: async reset mid-FLOW, between edges
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("ar_lanes", 32'(bus.lanes != 0), 0);
        chk("ar_total", 32'(bus.totalCars), 0);
        chk("ar_dep", 32'(bus.departPulse), 0);
        chk("ar_ovf", 32'(bus.overflow), 0);
        bus.greenLights = '0;
        tick();
        rst = 1'b1;
        tick();
        chk("ar_post_total", 32'(bus.totalCars), 0);
        chk("ar_post_busy", 32'(bus.laneBusy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
